// File: rtl/lcd_timing_gen.sv
// Programmable TFT timing generator with internal pixel divider, frame-boundary shadowed config and pixel prefetch strobe.
// Optional build macro LCD_TIMING_LINE_IRQ_EN adds the line_cmp register (address 9) and the line_irq compare.
module lcd_timing_gen #(
  parameter int         CNT_W       = 12,
  parameter int         COORD_W     = 11,
  parameter int         DIV_W       = 4,
  parameter int         LOOKAHEAD   = 2,
  parameter int         DEF_H_FRONT = 24,
  parameter int         DEF_H_SYNC  = 72,
  parameter int         DEF_H_BACK  = 96,
  parameter int         DEF_H_ACT   = 800,
  parameter int         DEF_V_FRONT = 3,
  parameter int         DEF_V_SYNC  = 10,
  parameter int         DEF_V_BACK  = 7,
  parameter int         DEF_V_ACT   = 480,
  parameter int         DEF_DIV     = 0,
  parameter logic [1:0] DEF_POL     = 2'b00
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_wr,
  input  logic [3:0]         cfg_addr,
  input  logic [CNT_W-1:0]   cfg_wdata,
  output logic               tick,
  output logic               hsync,
  output logic               vsync,
  output logic               data_enable,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               fetch_valid,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               next_frame,
  output logic               line_irq
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [CNT_W-1:0] sh_hf, sh_hs, sh_hb, sh_ha, sh_vf, sh_vs, sh_vb, sh_va;
  logic [DIV_W-1:0] sh_div;
  logic [1:0]       sh_pol;
  logic [CNT_W-1:0] a_hf, a_hs, a_hb, a_ha, a_vf, a_vs, a_vb, a_va;
  logic [DIV_W-1:0] a_div;
  logic [1:0]       a_pol;

  logic [CNT_W-1:0] h, v;
  logic [DIV_W-1:0] dcnt;
  logic             run;

  logic             run_en, tick_i, h_last, v_last, frame_end, load_act;
  logic [CNT_W-1:0] h_blank, h_total, v_blank, v_total;
  logic             hs_on, vs_on, h_vis, v_vis, vis, fetch_on;
  logic [CNT_W:0]   h_fetch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_hf  <= CNT_W'(DEF_H_FRONT);
      sh_hs  <= CNT_W'(DEF_H_SYNC);
      sh_hb  <= CNT_W'(DEF_H_BACK);
      sh_ha  <= CNT_W'(DEF_H_ACT);
      sh_vf  <= CNT_W'(DEF_V_FRONT);
      sh_vs  <= CNT_W'(DEF_V_SYNC);
      sh_vb  <= CNT_W'(DEF_V_BACK);
      sh_va  <= CNT_W'(DEF_V_ACT);
      sh_div <= DIV_W'(DEF_DIV);
      sh_pol <= DEF_POL;
    end else if (cfg_wr) begin
      case (cfg_addr)
        4'd0: sh_hf <= cfg_wdata;
        4'd1: sh_hs <= cfg_wdata;
        4'd2: sh_hb <= cfg_wdata;
        4'd3: sh_ha <= cfg_wdata;
        4'd4: sh_vf <= cfg_wdata;
        4'd5: sh_vs <= cfg_wdata;
        4'd6: sh_vb <= cfg_wdata;
        4'd7: sh_va <= cfg_wdata;
        4'd8: begin
          sh_div <= cfg_wdata[DIV_W+1:2];
          sh_pol <= cfg_wdata[1:0];
        end
        default: ;
      endcase
    end
  end

  // run masks the first clock after reset so tick stays low while state settles
  assign run_en    = enable & run;
  assign tick_i    = run_en & (dcnt == a_div);
  assign tick      = tick_i;

  assign h_blank   = a_hf + a_hs + a_hb;
  assign h_total   = h_blank + a_ha;
  assign v_blank   = a_vf + a_vs + a_vb;
  assign v_total   = v_blank + a_va;

  assign h_last    = (h == h_total - ONE);
  assign v_last    = (v == v_total - ONE);
  assign frame_end = tick_i & h_last & v_last;
  assign load_act  = ~run_en | frame_end;

  assign hs_on     = (h >= a_hf) && (h < a_hf + a_hs);
  assign vs_on     = (v >= a_vf) && (v < a_vf + a_vs);
  assign h_vis     = (h >= h_blank);
  assign v_vis     = (v >= v_blank);
  assign vis       = h_vis & v_vis;

  // fetch position never wraps into the next line, so the compare is against h_total
  assign h_fetch   = {1'b0, h} + (CNT_W+1)'(LOOKAHEAD);
  assign fetch_on  = v_vis && (h_fetch >= {1'b0, h_blank}) && (h_fetch < {1'b0, h_total});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_hf  <= CNT_W'(DEF_H_FRONT);
      a_hs  <= CNT_W'(DEF_H_SYNC);
      a_hb  <= CNT_W'(DEF_H_BACK);
      a_ha  <= CNT_W'(DEF_H_ACT);
      a_vf  <= CNT_W'(DEF_V_FRONT);
      a_vs  <= CNT_W'(DEF_V_SYNC);
      a_vb  <= CNT_W'(DEF_V_BACK);
      a_va  <= CNT_W'(DEF_V_ACT);
      a_div <= DIV_W'(DEF_DIV);
      a_pol <= DEF_POL;
    end else if (load_act) begin
      a_hf  <= sh_hf;
      a_hs  <= sh_hs;
      a_hb  <= sh_hb;
      a_ha  <= sh_ha;
      a_vf  <= sh_vf;
      a_vs  <= sh_vs;
      a_vb  <= sh_vb;
      a_va  <= sh_va;
      a_div <= sh_div;
      a_pol <= sh_pol;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      dcnt        <= '0;
      h           <= '0;
      v           <= '0;
      hsync       <= ~DEF_POL[0];
      vsync       <= ~DEF_POL[1];
      data_enable <= 1'b0;
      x           <= '0;
      y           <= '0;
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      next_frame  <= 1'b0;
    end else begin
      run        <= 1'b1;
      next_frame <= 1'b0;
      if (!run_en) begin
        dcnt        <= '0;
        h           <= '0;
        v           <= '0;
        hsync       <= ~sh_pol[0];
        vsync       <= ~sh_pol[1];
        data_enable <= 1'b0;
        x           <= '0;
        y           <= '0;
        fetch_valid <= 1'b0;
        fetch_x     <= '0;
        fetch_y     <= '0;
      end else if (tick_i) begin
        dcnt        <= '0;
        hsync       <= hs_on ? a_pol[0] : ~a_pol[0];
        vsync       <= vs_on ? a_pol[1] : ~a_pol[1];
        data_enable <= vis;
        x           <= vis ? COORD_W'(h - h_blank) : '0;
        y           <= vis ? COORD_W'(v - v_blank) : '0;
        fetch_valid <= fetch_on;
        fetch_x     <= fetch_on ? COORD_W'(h_fetch - {1'b0, h_blank}) : '0;
        fetch_y     <= fetch_on ? COORD_W'(v - v_blank) : '0;
        next_frame  <= (h == '0) && (v == a_vf);
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + ONE;
        end else begin
          h <= h + ONE;
        end
      end else begin
        dcnt <= dcnt + DIV_ONE;
      end
    end
  end

`ifdef LCD_TIMING_LINE_IRQ_EN
  logic [CNT_W-1:0] sh_lc, a_lc;
  logic             irq_hit, irq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         sh_lc <= '0;
    else if (cfg_wr && cfg_addr == 4'd9)  sh_lc <= cfg_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      a_lc <= '0;
    else if (load_act) a_lc <= sh_lc;
  end

  // v - v_blank stays below V_ACT, so a compare value >= V_ACT can never match
  assign irq_hit = (h == h_blank) && v_vis && ((v - v_blank) == a_lc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= tick_i & irq_hit;
  end

  assign line_irq = irq_q;
`else
  assign line_irq = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: frame-position reference model compared every clock, plus hand-computed timing literals.
// Define LCD_TIMING_LINE_IRQ_EN for both bench and RTL to exercise line_irq.
module tb_lcd_timing_gen;

  localparam int LA = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic        tick, hsync, vsync, data_enable, fetch_valid, next_frame, line_irq;
  logic [10:0] x, y, fetch_x, fetch_y;

  lcd_timing_gen dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .tick(tick), .hsync(hsync),
    .vsync(vsync), .data_enable(data_enable), .x(x), .y(y),
    .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .next_frame(next_frame), .line_irq(line_irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // config arrays: 0..7 timing fields, 8 div, 9 line_cmp, 10 polarity
  int sh[11];
  int act[11];
  int p, md, mrun;
  int e_hs, e_vs, e_de, e_x, e_y, e_fv, e_fx, e_fy, e_nf, e_irq;
  int last_tick;
  int win_open, decnt, nwin;
  int wins[8];

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    sh = '{24, 72, 96, 800, 3, 10, 7, 480, 0, 0, 0};
    act = sh;
    p = 0; md = 0; mrun = 0;
    e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0;
    e_fv = 0; e_fx = 0; e_fy = 0; e_nf = 0; e_irq = 0;
  endfunction

  function automatic int frame_len();
    return (act[0] + act[1] + act[2] + act[3]) * (act[4] + act[5] + act[6] + act[7]);
  endfunction

  function automatic int at_boundary();
    return (mrun != 0 && md == act[8] && p == frame_len() - 1) ? 1 : 0;
  endfunction

  // Outputs after one clock, computed from the linear pixel position inside the frame.
  function automatic void model_clock(input int en, input int wr, input int addr, input int data);
    int hb, ht, vb, h, v, fh, hp, vp;
    hb = act[0] + act[1] + act[2];
    ht = hb + act[3];
    vb = act[4] + act[5] + act[6];
    e_nf = 0;
    e_irq = 0;
    if (!(en != 0 && mrun != 0)) begin
      p = 0; md = 0;
      e_hs = 1 - (sh[10] & 1);
      e_vs = 1 - ((sh[10] >> 1) & 1);
      e_de = 0; e_x = 0; e_y = 0; e_fv = 0; e_fx = 0; e_fy = 0;
      act = sh;
    end else if (md == act[8]) begin
      h = p % ht;
      v = p / ht;
      hp = act[10] & 1;
      vp = (act[10] >> 1) & 1;
      e_hs = (h >= act[0] && h < act[0] + act[1]) ? hp : 1 - hp;
      e_vs = (v >= act[4] && v < act[4] + act[5]) ? vp : 1 - vp;
      e_de = (h >= hb && v >= vb) ? 1 : 0;
      e_x  = e_de ? h - hb : 0;
      e_y  = e_de ? v - vb : 0;
      fh   = h + LA;
      e_fv = (v >= vb && fh >= hb && fh < ht) ? 1 : 0;
      e_fx = e_fv ? fh - hb : 0;
      e_fy = e_fv ? v - vb : 0;
      e_nf = (h == 0 && v == act[4]) ? 1 : 0;
`ifdef LCD_TIMING_LINE_IRQ_EN
      e_irq = (h == hb && v >= vb && v - vb == act[9]) ? 1 : 0;
`endif
      md = 0;
      if (p == frame_len() - 1) begin
        p = 0;
        act = sh;
      end else begin
        p++;
      end
    end else begin
      md++;
    end
    if (wr != 0) begin
      if (addr <= 7) sh[addr] = data;
      else if (addr == 8) begin
        sh[8] = (data >> 2) & 15;
        sh[10] = data & 3;
      end
`ifdef LCD_TIMING_LINE_IRQ_EN
      else if (addr == 9) sh[9] = data;
`endif
    end
    mrun = 1;
  endfunction

  function automatic void check_outputs();
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("data_enable", int'(data_enable), e_de);
    chk("x", int'(x), e_x);
    chk("y", int'(y), e_y);
    chk("fetch_valid", int'(fetch_valid), e_fv);
    chk("fetch_x", int'(fetch_x), e_fx);
    chk("fetch_y", int'(fetch_y), e_fy);
    chk("next_frame", int'(next_frame), e_nf);
    chk("line_irq", int'(line_irq), e_irq);
  endfunction

  // One clock: drive at negedge, check tick, let the edge happen, check registered outputs.
  task automatic step(input int en, input int wr = 0, input int addr = 0, input int data = 0);
    enable    = (en != 0);
    cfg_wr    = (wr != 0);
    cfg_addr  = addr[3:0];
    cfg_wdata = data[11:0];
    #1;
    last_tick = int'(tick);
    chk("tick", last_tick, (en != 0 && mrun != 0 && md == act[8]) ? 1 : 0);
    @(posedge clock);
    model_clock(en, wr, addr, data);
    @(negedge clock);
    cfg_wr = 1'b0;
    check_outputs();
    if (next_frame) begin
      if (win_open != 0 && nwin < 8) begin
        wins[nwin] = decnt;
        nwin++;
      end
      win_open = 1;
      decnt = 0;
    end else if (data_enable) begin
      decnt++;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_tick", int'(tick), 0);
    check_outputs();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
  endtask

  task automatic wait_p(input int target);
    int n;
    n = 0;
    while (p != target && n < 3000) begin
      step(1);
      n++;
    end
    chk("wait_position", p, target);
  endtask

  task automatic small_config(input int lc);
    step(0, 1, 0, 2); step(0, 1, 1, 2); step(0, 1, 2, 2); step(0, 1, 3, 4);
    step(0, 1, 4, 1); step(0, 1, 5, 1); step(0, 1, 6, 1); step(0, 1, 7, 3);
    step(0, 1, 8, (2 << 2) | 3);
    step(0, 1, 9, lc);
    step(0);
  endtask

  function automatic int rand_val(input int addr);
    case (addr)
      0, 1:    return $urandom_range(0, 5);
      2:       return $urandom_range(2, 6);
      3:       return $urandom_range(1, 10);
      4, 5, 6: return $urandom_range(0, 3);
      7:       return $urandom_range(1, 4);
      8:       return ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      9:       return $urandom_range(0, 4);
      default: return $urandom_range(0, 4095);
    endcase
  endfunction

  initial begin
    int hs_first, hs_cnt, vs_first, fv_first, de_first, de_cnt, x_max;
    int n_tick, n_nf, n_hs_hi, k, n_irq;

    win_open = 0; decnt = 0; nwin = 0;
    model_reset();
    @(negedge clock);
    pulse_reset();
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_x", int'(x), 0);
    repeat (3) step(0);

    // default 992x500 timing, div 0
    hs_first = -1; hs_cnt = 0; vs_first = -1; fv_first = -1; de_first = -1; de_cnt = 0; x_max = 0;
    for (int i = 0; i < 21000; i++) begin
      step(1);
      if (i < 992 && hsync == 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_cnt++;
      end
      if (vsync == 1'b0 && vs_first < 0) vs_first = i;
      if (fetch_valid && fv_first < 0) fv_first = i;
      if (data_enable) begin
        if (de_first < 0) de_first = i;
        de_cnt++;
        if (int'(x) > x_max) x_max = int'(x);
      end
    end
    chk("def_hsync_first", hs_first, 24);
    chk("def_hsync_width", hs_cnt, 72);
    chk("def_vsync_first", vs_first, 2976);
    chk("def_fetch_first", fv_first, 20030);
    chk("def_de_first", de_first, 20032);
    chk("def_de_per_line", de_cnt, 800);
    chk("def_x_max", x_max, 799);

    // 10x6 timing, div 2, active-high syncs
    small_config(1);
    n_tick = 0; n_nf = 0; n_hs_hi = 0;
    for (int i = 0; i < 360; i++) begin
      step(1);
      n_tick += last_tick;
      if (next_frame) n_nf++;
      if (hsync) n_hs_hi++;
    end
    chk("small_ticks", n_tick, 120);
    chk("small_next_frame", n_nf, 2);
    chk("small_hsync_high", n_hs_hi, 72);

    // H_ACT 6 mid-frame, then H_ACT 4 on the boundary clock (deferred)
    win_open = 0; nwin = 0; decnt = 0;
    k = 0;
    while (win_open == 0 && k < 400) begin step(1); k++; end
    repeat (30) step(1);
    step(1, 1, 3, 6);
    k = 0;
    while (nwin < 1 && k < 400) begin step(1); k++; end
    k = 0;
    while (at_boundary() == 0 && k < 400) begin step(1); k++; end
    chk("boundary_found", at_boundary(), 1);
    step(1, 1, 3, 4);
    k = 0;
    while (nwin < 4 && k < 1500) begin step(1); k++; end
    chk("win_count", nwin, 4);
    chk("win0_de", wins[0], 36);
    chk("win1_de", wins[1], 54);
    chk("win2_de", wins[2], 54);
    chk("win3_de", wins[3], 36);

    // enable drop at v=2, h=5
    wait_p(25);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("idle_de", int'(data_enable), 0);
      chk("idle_fetch", int'(fetch_valid), 0);
      chk("idle_hsync", int'(hsync), 0);
    end
    k = 0;
    while (k < 2000) begin
      step(1);
      if (data_enable) break;
      k++;
    end
    chk("restart_first_de", k, 110);

    // async reset at v=2, h=5 restores defaults
    wait_p(25);
    pulse_reset();
    chk("midreset_hsync", int'(hsync), 1);
    chk("midreset_de", int'(data_enable), 0);
    repeat (400) step(1);

    // randomized configs, writes and enable drops
    for (int it = 0; it < 12; it++) begin
      step(0);
      for (int a = 0; a < 10; a++) step(0, 1, a, rand_val(a));
      step(0, 1, $urandom_range(10, 15), $urandom_range(0, 4095));
      step(0);
      k = $urandom_range(300, 1500);
      for (int i = 0; i < k; i++) begin
        int r, a;
        r = $urandom_range(0, 199);
        if (r < 6) begin
          a = $urandom_range(0, 12);
          step(1, 1, a, rand_val(a));
        end else if (r == 6) begin
          repeat ($urandom_range(1, 3)) step(0);
        end else if (r == 7 && it == 5) begin
          pulse_reset();
        end else begin
          step(1);
        end
      end
    end

`ifdef LCD_TIMING_LINE_IRQ_EN
    small_config(1);
    n_irq = 0;
    for (int i = 0; i < 360; i++) begin
      step(1);
      if (line_irq) begin
        n_irq++;
        chk("irq_row", int'(y), 1);
      end
    end
    chk("irq_count_cmp1", n_irq, 2);
    small_config(3);
    n_irq = 0;
    for (int i = 0; i < 360; i++) begin
      step(1);
      if (line_irq) n_irq++;
    end
    chk("irq_count_cmp3", n_irq, 0);
`else
    n_irq = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
